// File: rtl/pong_pkg.sv
// Shared pong constants and the paddle driver FSM encoding.
package pong_pkg;

    localparam int SCREEN_H = 474;
    localparam int SCREEN_W = 800;
    localparam int NET_X    = 390;
    localparam int PADDLE_H = 48;

    typedef enum logic {
        PD_IDLE,
        PD_STEP
    } paddle_state_t;

endpackage

// File: rtl/paddle_driver_if.sv
// Frame-tick/target inputs and paddle state outputs of paddle_driver.
interface paddle_driver_if;

    logic       FRAME_TICK;
    logic [7:0] POSITION;
    logic [8:0] PADDLE_Y;
    logic       MOVING;
    logic       DIR;
    logic       AT_TARGET;

    modport master (
        output FRAME_TICK, POSITION,
        input  PADDLE_Y, MOVING, DIR, AT_TARGET
    );

    modport slave (
        input  FRAME_TICK, POSITION,
        output PADDLE_Y, MOVING, DIR, AT_TARGET
    );

endinterface

// File: rtl/paddle_driver_step.sv
// Combinational single step: moves cur toward tgt by at most speed pixels.
module paddle_step (
    input  logic [8:0] i_cur,
    input  logic [8:0] i_tgt,
    input  logic [3:0] i_speed,
    output logic [8:0] o_next_y,
    output logic       o_moving,
    output logic       o_dir
);

    logic signed [9:0] w_diff;
    logic        [9:0] w_mag;
    logic        [8:0] w_step;

    assign w_diff   = $signed({1'b0, i_tgt}) - $signed({1'b0, i_cur});
    assign w_mag    = w_diff[9] ? 10'(-w_diff) : 10'(w_diff);
    // Limiting the step by |diff| is what prevents overshoot.
    assign w_step   = (w_mag < {6'd0, i_speed}) ? w_mag[8:0] : {5'd0, i_speed};
    assign o_moving = (w_diff != 10'sd0);
    assign o_dir    = ~w_diff[9];
    assign o_next_y = !o_moving ? i_cur :
                      w_diff[9] ? (i_cur - w_step) : (i_cur + w_step);

endmodule

// File: rtl/paddle_driver.sv
// Rate-limited paddle mover: one clamped step toward the AI target per frame.
// Optional acceleration ramp enabled by defining PADDLE_DRIVER_ACCEL_EN.
module paddle_driver #(
    parameter int SCREEN_H  = 474,
    parameter int PADDLE_H  = 48,
    parameter int MAX_SPEED = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    paddle_driver_if.slave   bus
);
    import pong_pkg::*;

    localparam logic [8:0] Y_LIM = 9'(SCREEN_H - PADDLE_H);
    localparam logic [8:0] Y_MID = 9'((SCREEN_H - PADDLE_H) / 2);

    paddle_state_t r_state, w_state_nxt;
    logic          w_cap, w_upd;

    logic [8:0] r_y, r_tgt;
    logic       r_moving, r_dir, r_at;

    logic [8:0] w_tgt_raw, w_tgt_clamp;
    logic [8:0] w_next_y;
    logic       w_moving, w_dir;
    logic [3:0] w_speed;

    assign w_tgt_raw   = {bus.POSITION, 1'b0};
    assign w_tgt_clamp = (w_tgt_raw > Y_LIM) ? Y_LIM : w_tgt_raw;

    always_ff @(posedge CLOCK) begin
        if (!RESET) r_state <= PD_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_upd       = 1'b0;
        case (r_state)
            PD_IDLE: if (bus.FRAME_TICK) begin
                w_cap       = 1'b1;
                w_state_nxt = PD_STEP;
            end
            PD_STEP: begin
                // Any tick seen here is dropped by design.
                w_upd       = 1'b1;
                w_state_nxt = PD_IDLE;
            end
            default: w_state_nxt = PD_IDLE;
        endcase
    end

`ifdef PADDLE_DRIVER_ACCEL_EN
    logic [3:0] r_speed, w_speed_nxt;
    logic       w_dir_req;

    // A reversal restarts the ramp on the reversing step itself.
    assign w_dir_req   = (r_tgt > r_y);
    assign w_speed     = (w_dir_req != r_dir) ? 4'd1 : r_speed;
    assign w_speed_nxt = !w_moving ? 4'd1 :
                         (w_speed >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : (w_speed + 4'd1);

    always_ff @(posedge CLOCK) begin
        if (!RESET)     r_speed <= 4'd1;
        else if (w_upd) r_speed <= w_speed_nxt;
    end
`else
    assign w_speed = 4'(MAX_SPEED);
`endif

    paddle_step u_step (
        .i_cur    (r_y),
        .i_tgt    (r_tgt),
        .i_speed  (w_speed),
        .o_next_y (w_next_y),
        .o_moving (w_moving),
        .o_dir    (w_dir)
    );

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_y      <= Y_MID;
            r_tgt    <= Y_MID;
            r_moving <= 1'b0;
            r_dir    <= 1'b0;
            r_at     <= 1'b1;
        end else begin
            if (w_cap) r_tgt <= w_tgt_clamp;
            if (w_upd) begin
                r_y      <= w_next_y;
                r_moving <= w_moving;
                if (w_moving) r_dir <= w_dir;
                r_at     <= (w_next_y == r_tgt);
            end
        end
    end

    assign bus.PADDLE_Y  = r_y;
    assign bus.MOVING    = r_moving;
    assign bus.DIR       = r_dir;
    assign bus.AT_TARGET = r_at;

endmodule

// File: tb/tb_paddle_driver.sv
// Scoreboard bench for paddle_driver; the reference model follows the frame rules directly.
// Define PADDLE_DRIVER_ACCEL_EN for both the RTL and this bench to test the accel build.
module tb_paddle_driver;

    localparam int YLIM = 426;
    localparam int YMID = 213;
    localparam int MAXS = 4;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    paddle_driver_if bus ();

    paddle_driver #(.SCREEN_H(474), .PADDLE_H(48), .MAX_SPEED(MAXS)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int y;
        bit mov;
        bit dir;
        bit at;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    int m_y, m_tgt, m_spd;
    bit m_mov, m_dir, m_at;

    // Results appear one edge after a sampled tick's capture edge; reset shows on its own edge.
    logic p0 = 1'b0, p1 = 1'b0, r0 = 1'b0;
    always @(posedge CLOCK) begin
        p0 <= bus.FRAME_TICK;
        p1 <= p0;
        r0 <= !RESET;
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic void push_exp();
        exp_t e;
        e.y = m_y; e.mov = m_mov; e.dir = m_dir; e.at = m_at;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_y = YMID; m_tgt = YMID; m_mov = 0; m_dir = 0; m_at = 1; m_spd = 1;
    endfunction

    function automatic void model_frame(input int pos);
        int t, d, s, st;
        bit nd;
        t = 2 * pos;
        if (t > YLIM) t = YLIM;
        m_tgt = t;
        d = t - m_y;
        if (d == 0) begin
            m_mov = 0;
            m_at  = 1;
            m_spd = 1;
        end else begin
            nd = (d > 0);
`ifdef PADDLE_DRIVER_ACCEL_EN
            s = (nd != m_dir) ? 1 : m_spd;
`else
            s = MAXS;
`endif
            st = (d > 0) ? d : -d;
            if (s < st) st = s;
            m_y   = nd ? m_y + st : m_y - st;
            m_mov = 1;
            m_dir = nd;
            m_at  = (m_y == t);
            m_spd = (s + 1 > MAXS) ? MAXS : s + 1;
        end
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLOCK);
            chk("y_in_range", int'(bus.PADDLE_Y <= 9'(YLIM)), 1);
            if (p1 || r0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_empty: output event with no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_paddle_y", int'(bus.PADDLE_Y), e.y);
                    chk("sb_moving", int'(bus.MOVING), int'(e.mov));
                    chk("sb_dir", int'(bus.DIR), int'(e.dir));
                    chk("sb_at_target", int'(bus.AT_TARGET), int'(e.at));
                end
            end
        end
    endtask

    // Called at a negedge; returns at a negedge with the step result visible.
    task automatic frame(input int pos, input int gap);
        bus.FRAME_TICK = 1'b1;
        bus.POSITION   = 8'(pos);
        model_frame(pos);
        push_exp();
        @(negedge CLOCK);
        bus.FRAME_TICK = 1'b0;
        bus.POSITION   = 8'($urandom);
        @(negedge CLOCK);
        repeat (gap) @(negedge CLOCK);
    endtask

    task automatic do_reset();
        model_reset();
        push_exp();
        RESET = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    initial begin
        int seq[5];
        int pos;
        fork
            monitor();
        join_none
        bus.FRAME_TICK = 1'b0;
        bus.POSITION   = 8'd0;
        model_reset();
        push_exp();
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("rst_y", int'(bus.PADDLE_Y), 213);
        chk("rst_at", int'(bus.AT_TARGET), 1);
        chk("rst_moving", int'(bus.MOVING), 0);
        chk("rst_dir", int'(bus.DIR), 0);

`ifdef PADDLE_DRIVER_ACCEL_EN
        seq = '{214, 216, 219, 223, 227};
        foreach (seq[i]) begin
            frame(255, 0);
            chk("accel_seq", int'(bus.PADDLE_Y), seq[i]);
        end
        frame(0, 0);
        chk("accel_rev1", int'(bus.PADDLE_Y), 226);
        chk("accel_rev1_dir", int'(bus.DIR), 0);
        frame(0, 0);
        chk("accel_rev2", int'(bus.PADDLE_Y), 224);
`else
        frame(15, 0);
        chk("up1_y", int'(bus.PADDLE_Y), 209);
        chk("up1_dir", int'(bus.DIR), 0);
        chk("up1_moving", int'(bus.MOVING), 1);
        repeat (45) frame(15, 0);
        chk("up46_y", int'(bus.PADDLE_Y), 30);
        chk("up46_at", int'(bus.AT_TARGET), 1);
        frame(15, 0);
        chk("up47_moving", int'(bus.MOVING), 0);
        chk("up47_y", int'(bus.PADDLE_Y), 30);

        do_reset();
        repeat (54) frame(255, 0);
        chk("clamp_y", int'(bus.PADDLE_Y), 426);
        chk("clamp_dir", int'(bus.DIR), 1);
        chk("clamp_at", int'(bus.AT_TARGET), 1);
        frame(255, 0);
        chk("clamp_hold_y", int'(bus.PADDLE_Y), 426);
        chk("clamp_hold_dir", int'(bus.DIR), 1);
`endif

        // Back-to-back ticks: the second lands in STEP and is ignored.
        do_reset();
        bus.FRAME_TICK = 1'b1;
        bus.POSITION   = 8'd15;
        model_frame(15);
        push_exp();
        @(negedge CLOCK);
        push_exp();
        @(negedge CLOCK);
        bus.FRAME_TICK = 1'b0;
        repeat (2) @(negedge CLOCK);
`ifdef PADDLE_DRIVER_ACCEL_EN
        chk("b2b_y", int'(bus.PADDLE_Y), 212);
`else
        chk("b2b_y", int'(bus.PADDLE_Y), 209);
`endif

        // Reset on the STEP cycle aborts the pending update.
        do_reset();
        bus.FRAME_TICK = 1'b1;
        bus.POSITION   = 8'd15;
        @(negedge CLOCK);
        bus.FRAME_TICK = 1'b0;
        model_reset();
        push_exp();
        RESET = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        chk("abort_y", int'(bus.PADDLE_Y), 213);
        chk("abort_at", int'(bus.AT_TARGET), 1);

        pos = 100;
        repeat (300) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            else begin
                if ($urandom_range(0, 7) == 0) pos = int'($urandom_range(0, 255));
                frame(pos, int'($urandom_range(0, 2)));
            end
        end

        repeat (4) @(negedge CLOCK);
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
